// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache sitting between IF1/IF2 and instruction memory.
// Hits are served combinationally in IF2; misses refill a whole line over a burst read port.
module inst_cache #(
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if1_addr,
    input  logic        stall_if1_if2,
    input  logic        inst_sram_rstn,
    output logic [31:0] inst,
    output logic        inst_sram_miss,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int LINES   = 1 << INDEX_BITS;
    localparam int WORDS   = 1 << OFFSET_BITS;
    localparam int WADDR_W = 30;
    localparam int LINE_W  = WADDR_W - OFFSET_BITS;
    localparam int TAG_W   = LINE_W - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RECV = 2'd2
    } state_e;

    // IF2 register holds a word address; the byte-offset bits never matter.
    logic [WADDR_W-1:0]     addr_q, addr_d;
    logic                   vld_q, vld_d;
    state_e                 state_q, state_d;
    logic [LINE_W-1:0]      refill_q, refill_d;
    logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
    logic [LINES-1:0]       valid_q, valid_d;

    logic [TAG_W-1:0]       tag_mem  [LINES];
    logic [31:0]            data_mem [LINES*WORDS];

    logic                   fill_we;
    logic                   tag_we;
    logic                   hit;
    logic [OFFSET_BITS-1:0] word;
    logic [INDEX_BITS-1:0]  idx;
    logic [TAG_W-1:0]       tag;
    logic [INDEX_BITS-1:0]  refill_idx;
    logic [TAG_W-1:0]       refill_tag;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^if1_addr[1:0];

    assign word       = addr_q[OFFSET_BITS-1:0];
    assign idx        = addr_q[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    assign tag        = addr_q[WADDR_W-1:OFFSET_BITS+INDEX_BITS];
    assign refill_idx = refill_q[INDEX_BITS-1:0];
    assign refill_tag = refill_q[LINE_W-1:INDEX_BITS];

    // IF2 address register: abort outranks the IF1->IF2 advance.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        addr_d = addr_q;
        vld_d  = vld_q;
        if (!inst_sram_rstn) begin
            vld_d = 1'b0;
        end else if (!stall_if1_if2) begin
            addr_d = if1_addr[31:2];
            vld_d  = 1'b1;
        end
    end

    always_comb begin
        hit            = vld_q && valid_q[idx] && (tag_mem[idx] == tag);
        inst           = hit ? data_mem[{idx, word}] : 32'h0;
        inst_sram_miss = vld_q && !hit;
    end

    // FSM next state plus the refill datapath it steers.
    always_comb begin
        state_d  = state_q;
        refill_d = refill_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        fill_we  = 1'b0;
        tag_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (inst_sram_miss && inst_sram_rstn) begin
                    refill_d     = addr_q[WADDR_W-1:OFFSET_BITS];
                    valid_d[idx] = 1'b0;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    cnt_d   = '0;
                    state_d = RECV;
                end else if (!inst_sram_rstn) begin
                    state_d = IDLE;
                end
            end
            RECV: begin
                // Once accepted, the burst always drains, even across an abort.
                if (mem_rvalid) begin
                    fill_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        tag_we              = 1'b1;
                        valid_d[refill_idx] = 1'b1;
                        state_d             = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req  = (state_q == REQ);
        mem_addr = mem_req ? {refill_q, {(OFFSET_BITS + 2){1'b0}}} : 32'h0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            addr_q   <= '0;
            vld_q    <= 1'b0;
            state_q  <= IDLE;
            refill_q <= '0;
            cnt_q    <= '0;
            valid_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            vld_q    <= vld_d;
            state_q  <= state_d;
            refill_q <= refill_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
        end
    end

    // NOTE: tag and data arrays are deliberately not reset; the valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[{refill_idx, cnt_q}] <= mem_rdata;
        end
        if (tag_we) begin
            tag_mem[refill_idx] <= refill_tag;
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed scenarios followed by random fetches
// checked against a line-presence model and an address-derived memory image.
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if1_addr;
    logic        stall_if1_if2;
    logic        inst_sram_rstn;
    logic [31:0] inst;
    logic        inst_sram_miss;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: which line (tag) each of the 64 indices currently holds.
    bit          model_valid [64];
    logic [21:0] model_tag   [64];

    inst_cache dut (
        .clk            (clk),
        .rst            (rst),
        .if1_addr       (if1_addr),
        .stall_if1_if2  (stall_if1_if2),
        .inst_sram_rstn (inst_sram_rstn),
        .inst           (inst),
        .inst_sram_miss (inst_sram_miss),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return model_valid[a[9:4]] && (model_tag[a[9:4]] == a[31:10]);
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic check1(input string name, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        if1_addr      = a;
        stall_if1_if2 = 1'b0;
        tick();
        stall_if1_if2 = 1'b1;
    endtask

    task automatic beat(input logic [31:0] d);
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic model_install(input logic [31:0] a);
        model_valid[a[9:4]] = 1'b1;
        model_tag[a[9:4]]   = a[31:10];
    endtask

    task automatic model_clear_all();
        for (int i = 0; i < 64; i++) model_valid[i] = 1'b0;
    endtask

    // Checks the IF2 result for address a against the model.
    task automatic expect_lookup(input string name, input logic [31:0] a);
        if (model_hit(a)) begin
            check1({name, " miss"}, inst_sram_miss, 1'b0);
            check({name, " inst"}, inst, mem_data(a));
        end else begin
            check1({name, " miss"}, inst_sram_miss, 1'b1);
            check({name, " inst"}, inst, 32'h0);
        end
    endtask

    // Waits (bounded) for the refill request of a's line; returns 1 if it appeared.
    task automatic wait_req(input string name, input logic [31:0] a, output bit ok);
        int n = 0;
        while (!mem_req && n < 8) begin
            tick();
            n++;
        end
        check1({name, " mem_req"}, mem_req, 1'b1);
        check({name, " mem_addr"}, mem_addr, {a[31:4], 4'h0});
        ok = mem_req;
    endtask

    // Serves a full refill for a's line with random ack delay and beat gaps, then checks the hit.
    task automatic do_refill(input string name, input logic [31:0] a);
        bit ok;
        logic [31:0] line;
        line = {a[31:4], 4'h0};
        wait_req(name, a, ok);
        if (!ok) return;
        repeat ($urandom_range(0, 2)) tick();
        check1({name, " miss held"}, inst_sram_miss, 1'b1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check1({name, " req dropped after ack"}, mem_req, 1'b0);
        for (int w = 0; w < 4; w++) begin
            repeat ($urandom_range(0, 2)) tick();
            beat(mem_data(line + 32'(4 * w)));
        end
        model_install(a);
        check1({name, " miss after fill"}, inst_sram_miss, 1'b0);
        check({name, " inst after fill"}, inst, mem_data(a));
    endtask

    logic [31:0] a;
    logic [21:0] tg;
    bit          ok;

    initial begin
        rst            = 1'b1;
        if1_addr       = 32'h0;
        stall_if1_if2  = 1'b1;
        inst_sram_rstn = 1'b1;
        mem_ack        = 1'b0;
        mem_rvalid     = 1'b0;
        mem_rdata      = 32'h0;
        model_clear_all();
        tick();
        tick();
        rst = 1'b0;
        check1("reset mem_req", mem_req, 1'b0);
        check("reset mem_addr", mem_addr, 32'h0);
        check1("reset miss", inst_sram_miss, 1'b0);
        check("reset inst", inst, 32'h0);

        // Cold miss on 0x100, then the three sequential hits in the same line.
        fetch(32'h100);
        check1("cold miss", inst_sram_miss, 1'b1);
        check1("cold no req yet", mem_req, 1'b0);
        tick();
        check1("cold req next cycle", mem_req, 1'b1);
        do_refill("cold", 32'h100);
        for (int w = 1; w < 4; w++) begin
            fetch(32'h100 + 32'(4 * w));
            expect_lookup("seq hit", 32'h100 + 32'(4 * w));
            check1("seq hit no req", mem_req, 1'b0);
        end

        // Conflict: 0x500 evicts 0x100 (same index, different tag).
        fetch(32'h500);
        expect_lookup("conflict", 32'h500);
        model_valid[5'h10] = 1'b0;
        do_refill("conflict", 32'h500);
        fetch(32'h100);
        check1("evicted refetch miss", inst_sram_miss, 1'b1);
        model_valid[5'h10] = 1'b0;
        do_refill("evicted refetch", 32'h100);

        // Abort before ack: the request is withdrawn and IF2 flushed.
        fetch(32'h200);
        check1("abort-req miss", inst_sram_miss, 1'b1);
        tick();
        check1("abort-req mem_req", mem_req, 1'b1);
        inst_sram_rstn = 1'b0;
        tick();
        inst_sram_rstn = 1'b1;
        check1("abort-req req dropped", mem_req, 1'b0);
        check1("abort-req miss cleared", inst_sram_miss, 1'b0);
        repeat (3) tick();
        check1("abort-req stays idle", mem_req, 1'b0);

        // Abort during RECV: burst drains, line installs, re-fetch hits after the last beat.
        fetch(32'h300);
        check1("abort-recv miss", inst_sram_miss, 1'b1);
        wait_req("abort-recv", 32'h300, ok);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        beat(mem_data(32'h300));
        beat(mem_data(32'h304));
        inst_sram_rstn = 1'b0;
        tick();
        inst_sram_rstn = 1'b1;
        check1("abort-recv flushed", inst_sram_miss, 1'b0);
        fetch(32'h300);
        check1("abort-recv refetch miss", inst_sram_miss, 1'b1);
        beat(mem_data(32'h308));
        check1("abort-recv miss before last", inst_sram_miss, 1'b1);
        beat(mem_data(32'h30C));
        model_install(32'h300);
        check1("abort-recv hit after drain", inst_sram_miss, 1'b0);
        check("abort-recv inst", inst, mem_data(32'h300));
        tick();
        check1("abort-recv no new req", mem_req, 1'b0);

        // Reset mid-burst: stray beats after reset are ignored, cache comes back empty.
        fetch(32'h600);
        check1("rst-burst miss", inst_sram_miss, 1'b1);
        wait_req("rst-burst", 32'h600, ok);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        beat(mem_data(32'h600));
        beat(mem_data(32'h604));
        rst = 1'b1;
        beat(mem_data(32'h608));
        rst = 1'b0;
        model_clear_all();
        check1("rst-burst mem_req", mem_req, 1'b0);
        check1("rst-burst miss", inst_sram_miss, 1'b0);
        check("rst-burst mem_addr", mem_addr, 32'h0);
        beat(mem_data(32'h60C));
        beat(32'hDEAD_BEEF);
        check1("stray beats no req", mem_req, 1'b0);
        fetch(32'h300);
        check1("post-reset 0x300 miss", inst_sram_miss, 1'b1);
        do_refill("post-reset", 32'h300);

        // Random fetches over a small set of tags and indices to force hits, conflicts and aborts.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       tg = 22'h0;
                1:       tg = 22'h1;
                2:       tg = 22'h3F_FFFF;
                default: tg = 22'h2A_AAAA;
            endcase
            a = {tg, 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
            fetch(a);
            expect_lookup("rnd", a);
            if (!model_hit(a)) begin
                model_valid[a[9:4]] = 1'b0;
                if ($urandom_range(0, 7) == 0) begin
                    wait_req("rnd abort", a, ok);
                    inst_sram_rstn = 1'b0;
                    tick();
                    inst_sram_rstn = 1'b1;
                    check1("rnd abort req dropped", mem_req, 1'b0);
                    check1("rnd abort flushed", inst_sram_miss, 1'b0);
                end else begin
                    do_refill("rnd", a);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
